mast_txn_arbiter: RTL and testbench

//   Shares one simple_master I2C engine between NUM_REQ requesters.
//   - Arbitrates pending requests and latches the winner's address, rd_wr and data.
//   - Pulses mast_start_bit, then watches the shared bus for the START and STOP conditions.
//   - Returns done, read data and error status to the granted requester.
//   - Sits between the system-side requesters and the master FSM/PISO/SIPO datapath.

---
 rtl/mast_txn_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mast_txn_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mast_txn_arbiter.sv
// Shares one I2C master engine among NUM_REQ requesters; round-robin, or fixed priority with MAST_ARB_FIXED_PRIO_EN.
// Latency: grant and start pulse one cycle after a request is seen in IDLE; done is registered after STOP or timeout.
// Backpressure: requests are level-held and ignored while a transaction is active or during the post-STOP gap.
module mast_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 512,
    parameter int GAP_CYC     = 8
) (
    input  logic                   fpga_clk,
    input  logic                   mast_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rd_wr,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [7:0]             rd_data,
    output logic                   mast_start_bit,
    output logic                   mast_rd_wr,
    output logic [6:0]             mast_address,
    output logic [7:0]             mast_data,
    input  logic [7:0]             data_from_slave,
    input  logic                   scl_mon,
    input  logic                   sda_mon
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

    state_t             state_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [GAP_W-1:0]   gap_q;
    logic               scl_s1_q, scl_s2_q;
    logic               sda_s1_q, sda_s2_q, sda_d_q;
    logic               start_det, stop_det, tmo_last;

    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [6:0]         sel_addr;
    logic [7:0]         sel_data;
    logic               sel_rd_wr;

    // Two-flop synchronizers idle high so reset looks like a free bus.
    always_ff @(posedge fpga_clk or negedge mast_rst) begin
        if (!mast_rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_d_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_mon;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_mon;
            sda_s2_q <= sda_s1_q;
            sda_d_q  <= sda_s2_q;
        end
    end

    assign start_det = scl_s2_q &  sda_d_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & ~sda_d_q &  sda_s2_q;
    assign tmo_last  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

`ifdef MAST_ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0]     rr_q;
    logic [2*NUM_REQ-1:0] req_rot;
    logic [IDX_W:0]       cand;

    // Rotating a doubled copy of req puts the rr pointer at bit 0.
    always_comb begin
        req_rot = {req, req} >> rr_q;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && req_rot[i]) begin
                win_vld = 1'b1;
                cand    = {1'b0, rr_q} + (IDX_W+1)'(i);
                if (cand >= (IDX_W+1)'(NUM_REQ))
                    cand = cand - (IDX_W+1)'(NUM_REQ);
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge fpga_clk or negedge mast_rst) begin
        if (!mast_rst)
            rr_q <= '0;
        else if (state_q == IDLE && win_vld)
            rr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
`endif

    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_rd_wr = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[7*i +: 7];
                sel_data  = req_data[8*i +: 8];
                sel_rd_wr = req_rd_wr[i];
            end
        end
    end

    always_ff @(posedge fpga_clk or negedge mast_rst) begin
        if (!mast_rst) begin
            state_q        <= IDLE;
            tmo_q          <= '0;
            gap_q          <= '0;
            grant          <= '0;
            done           <= '0;
            err            <= 1'b0;
            rd_data        <= '0;
            mast_start_bit <= 1'b0;
            mast_rd_wr     <= 1'b0;
            mast_address   <= '0;
            mast_data      <= '0;
        end else begin
            mast_start_bit <= 1'b0;
            done           <= '0;
            err            <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        grant          <= NUM_REQ'(1) << win_idx;
                        mast_address   <= sel_addr;
                        mast_data      <= sel_data;
                        mast_rd_wr     <= sel_rd_wr;
                        mast_start_bit <= 1'b1;
                        tmo_q          <= '0;
                        state_q        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (tmo_last) begin
                        done    <= grant;
                        err     <= 1'b1;
                        grant   <= '0;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (start_det)
                            state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A real STOP wins over a coincident timeout.
                    if (stop_det) begin
                        if (mast_rd_wr)
                            rd_data <= data_from_slave;
                        done    <= grant;
                        grant   <= '0;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else if (tmo_last) begin
                        done    <= grant;
                        err     <= 1'b1;
                        grant   <= '0;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_W'(GAP_CYC - 1))
                        state_q <= IDLE;
                    else
                        gap_q <= gap_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mast_txn_arbiter.sv
// Directed bench for mast_txn_arbiter: reset, write, read, timeout, gap and arbitration order.
module tb_mast_txn_arbiter;
    localparam int TMO = 512;
    localparam int GAP = 8;

    logic        fpga_clk = 1'b0;
    logic        mast_rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_rd_wr = '0;
    logic [27:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [7:0]  data_from_slave = '0;
    logic        scl_mon = 1'b1;
    logic        sda_mon = 1'b1;
    logic [3:0]  grant, done;
    logic        err, mast_start_bit, mast_rd_wr;
    logic [7:0]  rd_data, mast_data;
    logic [6:0]  mast_address;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    mast_txn_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .fpga_clk(fpga_clk), .mast_rst(mast_rst), .req(req), .req_rd_wr(req_rd_wr),
        .req_addr(req_addr), .req_data(req_data), .grant(grant), .done(done), .err(err),
        .rd_data(rd_data), .mast_start_bit(mast_start_bit), .mast_rd_wr(mast_rd_wr),
        .mast_address(mast_address), .mast_data(mast_data),
        .data_from_slave(data_from_slave), .scl_mon(scl_mon), .sda_mon(sda_mon)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge fpga_clk);
    endtask

    task automatic apply_reset();
        mast_rst = 1'b0;
        sda_mon  = 1'b1;
        scl_mon  = 1'b1;
        wait_cyc(3);
        mast_rst = 1'b1;
        wait_cyc(2);
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (!mast_start_bit && n < budget) begin
            @(negedge fpga_clk);
            n++;
        end
        if (!mast_start_bit) check_eq("start_seen", mast_start_bit, 1);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done == 4'b0 && n < budget) begin
            @(negedge fpga_clk);
            n++;
        end
        if (done == 4'b0) check_eq("done_seen", done, 4'b1111);
    endtask

    // START (SDA falls with SCL high) followed by STOP (SDA rises with SCL high).
    task automatic bus_txn();
        sda_mon = 1'b0;
        wait_cyc(6);
        sda_mon = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_g;
        wait_cyc(3);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_start", mast_start_bit, 0);
        check_eq("rst_addr", mast_address, 0);
        check_eq("rst_rd_data", rd_data, 0);
        mast_rst = 1'b1;
        wait_cyc(2);

        // Reset mid-BUSY, then prove the FSM restarts from IDLE.
        req = 4'b0001;
        req_addr[6:0] = 7'h50;
        req_data[7:0] = 8'hA5;
        wait_start(20, cyc);
        sda_mon = 1'b0;
        wait_cyc(5);
        mast_rst = 1'b0;
        sda_mon  = 1'b1;
        #1;
        check_eq("midrst_grant", grant, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_start", mast_start_bit, 0);
        req = 4'b0000;
        wait_cyc(2);
        mast_rst = 1'b1;
        wait_cyc(3);
        check_eq("postrst_done", done, 0);
        req = 4'b0001;
        wait_start(20, cyc);
        check_eq("postrst_idle_latency", cyc, 1);
        req = 4'b0000;
        apply_reset();

        // Single write on requester 0.
        req = 4'b0001;
        req_rd_wr = 4'b0000;
        data_from_slave = 8'h77;
        wait_start(20, cyc);
        check_eq("wr_grant", grant, 4'b0001);
        check_eq("wr_addr", mast_address, 7'h50);
        check_eq("wr_data", mast_data, 8'hA5);
        check_eq("wr_rdwr", mast_rd_wr, 0);
        wait_cyc(1);
        check_eq("wr_start_1cyc", mast_start_bit, 0);
        bus_txn();
        wait_done(100, cyc);
        check_eq("wr_done", done, 4'b0001);
        check_eq("wr_err", err, 0);
        check_eq("wr_rd_data_kept", rd_data, 8'h00);
        req = 4'b0000;
        wait_cyc(1);
        check_eq("wr_done_pulse", done, 0);
        check_eq("wr_grant_drop", grant, 0);

        // Read on requester 1; req dropped after launch must still complete.
        req = 4'b0010;
        req_rd_wr = 4'b0010;
        req_addr[13:7] = 7'h21;
        data_from_slave = 8'h3C;
        wait_start(50, cyc);
        check_eq("rd_grant", grant, 4'b0010);
        check_eq("rd_addr", mast_address, 7'h21);
        check_eq("rd_rdwr", mast_rd_wr, 1);
        req = 4'b0000;
        bus_txn();
        wait_done(100, cyc);
        check_eq("rd_done", done, 4'b0010);
        check_eq("rd_data", rd_data, 8'h3C);
        check_eq("rd_err", err, 0);

        // Timeout: launch with no START on the bus.
        req = 4'b0100;
        req_rd_wr = 4'b0100;
        data_from_slave = 8'h99;
        wait_start(50, cyc);
        check_eq("tmo_grant", grant, 4'b0100);
        wait_done(TMO + 20, cyc);
        check_eq("tmo_latency", cyc, TMO);
        check_eq("tmo_done", done, 4'b0100);
        check_eq("tmo_err", err, 1);
        check_eq("tmo_rd_data_kept", rd_data, 8'h3C);
        req = 4'b0000;
        wait_cyc(1);
        check_eq("tmo_err_pulse", err, 0);

        // Gap: request held through done, next start exactly GAP+1 cycles later.
        req = 4'b1000;
        req_rd_wr = 4'b0000;
        req_addr[27:21] = 7'h0F;
        wait_start(50, cyc);
        check_eq("gap_addr", mast_address, 7'h0F);
        bus_txn();
        wait_done(100, cyc);
        check_eq("gap_done", done, 4'b1000);
        wait_start(50, cyc);
        check_eq("gap_latency", cyc, GAP + 1);
        check_eq("gap_regrant", grant, 4'b1000);
        req = 4'b0000;
        apply_reset();

        // All four requesting from reset: arbitration order.
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
`ifdef MAST_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'b0001 << i;
`endif
            wait_start(50, cyc);
            check_eq("arb_grant", grant, exp_g);
            bus_txn();
            wait_done(100, cyc);
            check_eq("arb_done", done, exp_g);
        end
        req = 4'b0000;
        wait_cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
